// File: rtl/led_out_pkg.sv
// Shared constants and types for the LED output stage.
// The LED word is {count, shift}: the count RP drives the upper nibble and
// the shift RP drives the lower nibble.
package led_out_pkg;

  localparam int unsigned N_LED    = 8;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned SHIFT_LO = 0;
  localparam int unsigned COUNT_LO = 4;

  // RUN    : LEDs follow the RP outputs.
  // FROZEN : an RP is being reconfigured, so the last good value is held.
  // SETTLE : waiting for the RP outputs to stay stable before following them again.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FROZEN = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator for LED dimming.
//
// A free-running period counter is compared against a brightness latch.
// The latch (duty_q) loads only on the last count of a period, so a duty
// change never alters a period that is already running.
//
// Optional feature: define LED_OUT_GAMMA_EN to compare against a
// gamma-corrected duty, (duty_q^2) >> PWM_BITS. The corrected value is also
// loaded at period end, so a duty change takes effect one period later than
// in the default build.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high
//   duty     : requested brightness (0 = off, all-ones = fully on)
//   pwm_on_c : combinational PWM enable for the current count
//   pwm_sync : registered; high during the cycle in which the count is 0
module led_pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on_c,
  output logic                pwm_sync
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_eff;
  logic                at_max_c;

  assign at_max_c = (pwm_cnt == PWM_MAX);

  // Period counter, period-aligned duty latch and sync pulse. The pulse is
  // registered from the last count so that it lines up with count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      duty_q   <= PWM_MAX;
      pwm_sync <= 1'b0;
    end else begin
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      pwm_sync <= at_max_c;
      if (at_max_c) begin
        duty_q <= duty;
      end
    end
  end

`ifdef LED_OUT_GAMMA_EN
  localparam int unsigned SQ_W = 2 * PWM_BITS;

  logic [SQ_W-1:0] duty_sq_c;

  assign duty_sq_c = SQ_W'(duty_q) * SQ_W'(duty_q);

  // Sampled at period end together with duty_q, so it lags by one period.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_eff <= PWM_MAX;
    end else if (at_max_c) begin
      duty_eff <= duty_sq_c[SQ_W-1:PWM_BITS];
    end
  end
`else
  assign duty_eff = duty_q;
`endif

  // Full scale is forced on so that the LEDs have no dark cycle at all-ones.
  assign pwm_on_c = (pwm_cnt < duty_eff) | (duty_q == PWM_MAX);

endmodule

// File: rtl/led_out_stage.sv
// Static-region LED driver fed by the shift and count reconfigurable partitions.
//
// The block registers {count_in, shift_in} and drives the board LEDs through
// a PWM dimmer. While decouple is high, it holds the last good value. After
// decouple releases, the block follows the RP outputs again only once they
// have stayed stable for SETTLE_CYCLES consecutive cycles.
//
// Optional feature: LED_OUT_GAMMA_EN (see led_pwm_gen) enables gamma-corrected dimming.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high
//   decouple : high while an RP is being reconfigured; RP outputs are invalid
//   shift_in : shift RP data_out  -> led[3:0]
//   count_in : count RP count_out -> led[7:4]
//   duty     : PWM brightness (0 = off, all-ones = fully on)
//   led      : registered {count, shift} gated by PWM
//   frozen   : registered; high whenever the block is not in RUN
//   pwm_sync : registered; one-cycle pulse at the start of each PWM period
module led_out_stage
  import led_out_pkg::*;
#(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                decouple,
  input  logic [NIB_W-1:0]    shift_in,
  input  logic [NIB_W-1:0]    count_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LED-1:0]    led,
  output logic                frozen,
  output logic                pwm_sync
);

  localparam int unsigned       CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state;
  state_t             state_d;
  logic [N_LED-1:0]   sample_c;
  logic [N_LED-1:0]   sample_prev;
  logic [N_LED-1:0]   captured;
  logic [N_LED-1:0]   captured_d;
  logic [CNT_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   settle_cnt_d;
  logic               stable_c;
  logic               pwm_on_c;

  // Assemble the LED word from the two RP nibbles.
  always_comb begin
    sample_c                       = '0;
    sample_c[SHIFT_LO +: NIB_W]    = shift_in;
    sample_c[COUNT_LO +: NIB_W]    = count_in;
  end

  assign stable_c = (sample_c == sample_prev);

  // Freeze/settle next state. Decouple always wins over settle completion.
  // The counter only increments below CNT_LAST, so it saturates and never wraps.
  always_comb begin
    state_d      = state;
    captured_d   = captured;
    settle_cnt_d = settle_cnt;
    unique case (state)
      RUN: begin
        if (decouple) begin
          state_d = FROZEN;
        end else begin
          captured_d = sample_c;
        end
      end
      FROZEN: begin
        settle_cnt_d = '0;
        if (!decouple) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (decouple) begin
          state_d = FROZEN;
        end else if (!stable_c) begin
          settle_cnt_d = '0;
        end else if (settle_cnt == CNT_LAST) begin
          state_d      = RUN;
          captured_d   = sample_c;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  // State register plus the capture, history and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SETTLE;
      captured    <= '0;
      sample_prev <= '0;
      settle_cnt  <= '0;
      led         <= '0;
      frozen      <= 1'b1;
    end else begin
      state       <= state_d;
      captured    <= captured_d;
      sample_prev <= sample_c;
      settle_cnt  <= settle_cnt_d;
      led         <= captured & {N_LED{pwm_on_c}};
      frozen      <= (state_d != RUN);
    end
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .duty     (duty),
    .pwm_on_c (pwm_on_c),
    .pwm_sync (pwm_sync)
  );

endmodule
